inv_sub_bytes_seq: RTL and testbench



---
 rtl/inv_sub_bytes_seq_if.sv | 15 +
 rtl/inv_sub_bytes_seq.sv | 99 +++++++++
 tb/tb_inv_sub_bytes_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for the iterative InvSubBytes engine: one input state
// channel and one output result channel, both valid/ready.
interface inv_sub_bytes_seq_if;
  logic         IN_valid;
  logic         IN_ready;
  logic [127:0] IN_state;
  logic         OUT_valid;
  logic         OUT_ready;
  logic [127:0] OUT_state;

  modport master (output IN_valid, IN_state, OUT_ready,
                  input  IN_ready, OUT_valid, OUT_state);
  modport slave  (input  IN_valid, IN_state, OUT_ready,
                  output IN_ready, OUT_valid, OUT_state);
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes per clock,
// byte 0 (MSB) first, through a shared bank of inverse S-box lanes.
module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [7:0] TAB [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };
  assign o_byte = TAB[i_byte];
endmodule

module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                clk,
  input  logic                reset,
  inv_sub_bytes_seq_if.slave  bus
);
  localparam int BEATS = 16 / BYTES_PER_CYCLE;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                              r_state, w_state_nxt;
  logic [15:0][7:0]                    r_work, w_next;
  logic [127:0]                        r_out;
  logic [CW-1:0]                       r_cnt;
  logic [3:0]                          w_base;
  logic                                w_last, w_accept;
  logic [BYTES_PER_CYCLE-1:0][7:0]     w_lane_in, w_lane_out;

  // Byte k of the state lives in r_work[15-k], so byte 0 maps to [127:120].
  assign w_base   = 4'(int'(r_cnt) * BYTES_PER_CYCLE);
  assign w_last   = (r_cnt == CW'(BEATS - 1));
  assign w_accept = bus.IN_valid & bus.IN_ready;

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    assign w_lane_in[j] = r_work[4'd15 - (w_base + 4'(j))];
    inv_sbox u_sbox (.i_byte(w_lane_in[j]), .o_byte(w_lane_out[j]));
  end

  always_comb begin
    w_next = r_work;
    for (int j = 0; j < BYTES_PER_CYCLE; j++)
      w_next[4'd15 - (w_base + 4'(j))] = w_lane_out[j];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.IN_valid) w_state_nxt = BUSY;
      BUSY:    if (w_last)       w_state_nxt = DONE;
      DONE:    if (bus.OUT_ready) w_state_nxt = bus.IN_valid ? BUSY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.IN_ready  = !reset && ((r_state == IDLE) || (r_state == DONE && bus.OUT_ready));
    bus.OUT_valid = (r_state == DONE);
    bus.OUT_state = r_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else if (w_accept) begin
      r_work <= bus.IN_state;
      r_cnt  <= '0;
    end else if (r_state == BUSY) begin
      r_work <= w_next;
      r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last) r_out <= w_next;
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: three instances (4, 1, 16 bytes/cycle) against
// an inverse S-box derived from GF(2^8) inversion plus the AES affine map.
module tb_inv_sub_bytes_seq;
  localparam logic [127:0] V_IN  = 128'h87EC4A8CF26EC3D84D4C46959790E7A6;
  localparam logic [127:0] V_OUT = 128'hEA835CF00445332D655D98AD8596B0C5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inv_sub_bytes_seq_if bus4();
  inv_sub_bytes_seq_if bus1();
  inv_sub_bytes_seq_if bus16();

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  int total = 0;
  int bad   = 0;
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_isb(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[s[127-8*k -: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Single transaction on the 4-lane instance with OUT_ready held high.
  task automatic send4(input logic [127:0] d, output logic [127:0] res, output int lat);
    int w;
    w = 0;
    bus4.OUT_ready = 1'b1;
    while (!bus4.IN_ready && w < 20) begin tick(); w++; end
    bus4.IN_state = d;
    bus4.IN_valid = 1'b1;
    tick();
    bus4.IN_valid = 1'b0;
    bus4.IN_state = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!bus4.OUT_valid && lat < 40) begin tick(); lat++; end
    res = bus4.OUT_state;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus4.OUT_valid, bus4.IN_ready, bus4.OUT_state} !== 130'h0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: valid=%b ready=%b state=%h want 0/0/0",
                 i, bus4.OUT_valid, bus4.IN_ready, bus4.OUT_state);
      end
      total++;
      if ({bus1.OUT_valid, bus16.OUT_valid, bus1.IN_ready, bus16.IN_ready} !== 4'b0) begin
        bad++;
        $display("FAIL reset_hold_variants cyc%0d: got %b want 0000", i,
                 {bus1.OUT_valid, bus16.OUT_valid, bus1.IN_ready, bus16.IN_ready});
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if ({bus4.IN_ready, bus1.IN_ready, bus16.IN_ready, bus4.OUT_valid} !== 4'b1110) begin
      bad++;
      $display("FAIL reset_release: ready4/1/16,valid4=%b want 1110",
               {bus4.IN_ready, bus1.IN_ready, bus16.IN_ready, bus4.OUT_valid});
    end
  endtask

  task automatic test_vector();
    logic [127:0] res; int lat;
    send4(V_IN, res, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL vector_latency: got %0d want 4", lat); end
    total++;
    if (res !== V_OUT) begin bad++; $display("FAIL vector_state: got %h want %h", res, V_OUT); end
  endtask

  task automatic test_byte_map();
    logic [7:0] pin  [3];
    logic [7:0] pout [3];
    logic [127:0] res; int lat;
    pin  = '{8'h63, 8'h00, 8'h16};
    pout = '{8'h00, 8'h52, 8'hff};
    for (int i = 0; i < 3; i++) begin
      send4({16{pin[i]}}, res, lat);
      total++;
      if (res !== {16{pout[i]}} || lat !== 4) begin
        bad++;
        $display("FAIL byte_map %h: got %h lat %0d want %h lat 4", pin[i], res, lat, {16{pout[i]}});
      end
    end
  endtask

  task automatic test_all_bytes();
    logic [127:0] d, res; int lat;
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = 8'(s * 16 + k);
      send4(d, res, lat);
      total++;
      if (res !== ref_isb(d)) begin
        bad++;
        $display("FAIL all_bytes %0d: got %h want %h", s, res, ref_isb(d));
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] d, res; int lat;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send4(d, res, lat);
      total++;
      if (res !== ref_isb(d) || lat !== 4) begin
        bad++;
        $display("FAIL random %0d: got %h lat %0d want %h lat 4", i, res, lat, ref_isb(d));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d1, d2; int n;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    bus4.OUT_ready = 1'b0;
    bus4.IN_state  = d1;
    bus4.IN_valid  = 1'b1;
    tick();
    bus4.IN_state = d2;
    n = 0;
    while (!bus4.OUT_valid && n < 40) begin
      tick(); n++;
      total++;
      if (!bus4.OUT_valid && bus4.IN_ready !== 1'b0) begin
        bad++; $display("FAIL busy_ignore: ready=%b want 0 while busy", bus4.IN_ready);
      end
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus4.OUT_valid, bus4.IN_ready, bus4.OUT_state} !== {1'b1, 1'b0, ref_isb(d1)}) begin
        bad++;
        $display("FAIL backpressure cyc%0d: valid=%b ready=%b state=%h want 1/0/%h",
                 i, bus4.OUT_valid, bus4.IN_ready, bus4.OUT_state, ref_isb(d1));
      end
      tick();
    end
    bus4.OUT_ready = 1'b1;
    #1;
    total++;
    if (bus4.IN_ready !== 1'b1) begin bad++; $display("FAIL handoff_ready: got %b want 1", bus4.IN_ready); end
    tick();
    bus4.IN_valid = 1'b0;
    total++;
    if ({bus4.OUT_valid, bus4.IN_ready} !== 2'b00) begin
      bad++; $display("FAIL handoff_accept: valid,ready=%b want 00", {bus4.OUT_valid, bus4.IN_ready});
    end
    n = 0;
    while (!bus4.OUT_valid && n < 40) begin tick(); n++; end
    total++;
    if (n !== 4 || bus4.OUT_state !== ref_isb(d2)) begin
      bad++;
      $display("FAIL back_to_back: got %h lat %0d want %h lat 4", bus4.OUT_state, n, ref_isb(d2));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [127:0] res; int lat, n; logic seen;
    bus4.OUT_ready = 1'b1;
    bus4.IN_state  = {$urandom, $urandom, $urandom, $urandom};
    bus4.IN_valid  = 1'b1;
    tick();
    bus4.IN_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({bus4.OUT_valid, bus4.IN_ready} !== 2'b01) begin
      bad++; $display("FAIL reset_busy: valid,ready=%b want 01", {bus4.OUT_valid, bus4.IN_ready});
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (bus4.OUT_valid !== 1'b0) seen = 1'b1; end
    total++;
    if (seen) begin bad++; $display("FAIL reset_busy_no_valid: got valid=1 want 0"); end
    // abandon a finished result while it waits in DONE
    bus4.OUT_ready = 1'b0;
    bus4.IN_state  = {$urandom, $urandom, $urandom, $urandom};
    bus4.IN_valid  = 1'b1;
    tick();
    bus4.IN_valid = 1'b0;
    n = 0;
    while (!bus4.OUT_valid && n < 40) begin tick(); n++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({bus4.OUT_valid, bus4.IN_ready} !== 2'b01) begin
      bad++; $display("FAIL reset_done: valid,ready=%b want 01", {bus4.OUT_valid, bus4.IN_ready});
    end
    send4({16{8'h63}}, res, lat);
    total++;
    if (res !== 128'h0 || lat !== 4) begin
      bad++; $display("FAIL reset_recover: got %h lat %0d want 0 lat 4", res, lat);
    end
  endtask

  task automatic test_lane_variants();
    int lat1, lat16;
    logic [127:0] r1, r16, d;
    for (int t = 0; t < 2; t++) begin
      d = (t == 0) ? V_IN : {$urandom, $urandom, $urandom, $urandom};
      bus1.OUT_ready = 1'b1; bus16.OUT_ready = 1'b1;
      bus1.IN_state = d;     bus16.IN_state = d;
      bus1.IN_valid = 1'b1;  bus16.IN_valid = 1'b1;
      tick();
      bus1.IN_valid = 1'b0;  bus16.IN_valid = 1'b0;
      lat1 = 0; lat16 = 0; r1 = '0; r16 = '0;
      for (int n = 1; n <= 40 && (lat1 == 0 || lat16 == 0); n++) begin
        tick();
        if (lat1 == 0 && bus1.OUT_valid === 1'b1)   begin lat1 = n;  r1 = bus1.OUT_state;  end
        if (lat16 == 0 && bus16.OUT_valid === 1'b1) begin lat16 = n; r16 = bus16.OUT_state; end
      end
      tick();
      total++;
      if (lat1 !== 16 || r1 !== ref_isb(d)) begin
        bad++; $display("FAIL bpc1 t%0d: got %h lat %0d want %h lat 16", t, r1, lat1, ref_isb(d));
      end
      total++;
      if (lat16 !== 1 || r16 !== ref_isb(d)) begin
        bad++; $display("FAIL bpc16 t%0d: got %h lat %0d want %h lat 1", t, r16, lat16, ref_isb(d));
      end
    end
    total++;
    if (r1 !== r16) begin bad++; $display("FAIL variants_agree: bpc1 %h bpc16 %h", r1, r16); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int x = 0; x < 256; x++) inv_tab[sbox_fwd(8'(x))] = 8'(x);
    reset = 1'b1;
    bus4.IN_valid = 1'b0;  bus4.IN_state = '0;  bus4.OUT_ready = 1'b0;
    bus1.IN_valid = 1'b0;  bus1.IN_state = '0;  bus1.OUT_ready = 1'b0;
    bus16.IN_valid = 1'b0; bus16.IN_state = '0; bus16.OUT_ready = 1'b0;
    test_reset();
    test_vector();
    test_byte_map();
    test_all_bytes();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_lane_variants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
